sid_readback: RTL and testbench

Read-side register port of the SID audio block. Serves CPU reads at 0x19–0x1C: POTX/POTY from a free-running 512-tick paddle measurement sequencer, plus OSC3/ENV3 snapshots of voice 2. Every other address returns the decaying data-bus latch. Sits beside the SID write-register file on the same addr/data/n_cs/rw bus; its data_out is muxed onto the CPU data bus by the top level.

---
 rtl/sid_pkg.sv | 24 ++
 rtl/sid_pot_channel.sv | 60 ++++++
 rtl/sid_readback.sv | 133 +++++++++++++
 tb/tb_sid_readback.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared constants and types for the SID read-side register port
//
// Purpose: register addresses served by sid_readback, the paddle sequencer
//          state type and the length of one sequencer phase.
// Ports:   none (package).

package sid_pkg;

  localparam logic [4:0] SID_POTX = 5'h19;
  localparam logic [4:0] SID_POTY = 5'h1A;
  localparam logic [4:0] SID_OSC3 = 5'h1B;
  localparam logic [4:0] SID_ENV3 = 5'h1C;

  typedef enum logic {
    POT_DISCHARGE,
    POT_CHARGE
  } pot_state_t;

  localparam int POT_PHASE_LEN = 256;

  // Last phase-counter value of either phase.
  localparam logic [7:0] POT_LAST = 8'(POT_PHASE_LEN - 1);

endpackage

// File: rtl/sid_pot_channel.sv
// rtl/sid_pot_channel.sv - one paddle channel: capture on first comparator hit, commit at period end
//
// Purpose: during CHARGE, latches the phase count on the first tick the
//          comparator reads 1, and at the last CHARGE tick publishes that
//          count (or 0xFF if nothing was captured).
// Ports:
//   clk, n_reset  clock, asynchronous active-low reset
//   clk_en        phase-2 tick enable
//   state, pcnt   sequencer state and phase counter from the top
//   cmp           paddle comparator, 1 = capacitor above threshold
//   value         committed 8-bit paddle reading

module sid_pot_channel
  import sid_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       clk_en,
  input  pot_state_t state,
  input  logic [7:0] pcnt,
  input  logic       cmp,
  output logic [7:0] value
);

  logic       cap_flag_q, cap_flag_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] value_q, value_d;

  always_comb begin
    cap_flag_d = cap_flag_q;
    cap_d      = cap_q;
    value_d    = value_q;
    if (clk_en && state == POT_CHARGE) begin
      // The commit tick ignores the comparator, so a hit exactly at the
      // last count reads the same as a timeout.
      if (pcnt == POT_LAST) begin
        value_d    = cap_flag_q ? cap_q : 8'hFF;
        cap_flag_d = 1'b0;
      end else if (!cap_flag_q && cmp) begin
        cap_flag_d = 1'b1;
        cap_d      = pcnt;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cap_flag_q <= 1'b0;
      cap_q      <= 8'h00;
      value_q    <= 8'h00;
    end else begin
      cap_flag_q <= cap_flag_d;
      cap_q      <= cap_d;
      value_q    <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/sid_readback.sv
// rtl/sid_readback.sv - SID read-side registers: POTX/POTY, OSC3/ENV3 and decaying bus latch
//
// Purpose: serves CPU reads at 0x19-0x1C, runs the 512-tick paddle
//          discharge/charge sequencer, and keeps the data-bus latch that
//          every other address reads back, clearing it after DECAY_TICKS
//          idle clk_en ticks.
// Ports:
//   clk, n_reset            clock, asynchronous active-low reset
//   clk_en                  phase-2 tick; paces sequencer and decay
//   addr, data_in, n_cs, rw shared SID register bus (rw=1 read)
//   osc3, env3              voice 2 waveform / envelope snapshot sources
//   pot_x_cmp, pot_y_cmp    paddle comparators
//   pot_discharge           1 = ground the paddle capacitors
//   data_out                registered read data

module sid_readback
  import sid_pkg::*;
#(
  parameter int unsigned DECAY_TICKS = 2000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       clk_en,
  input  logic [4:0] addr,
  input  logic [7:0] data_in,
  input  logic       n_cs,
  input  logic       rw,
  input  logic [7:0] osc3,
  input  logic [7:0] env3,
  input  logic       pot_x_cmp,
  input  logic       pot_y_cmp,
  output logic       pot_discharge,
  output logic [7:0] data_out
);

  localparam logic [15:0] DECAY_RELOAD = 16'(DECAY_TICKS);

  pot_state_t  state_q, state_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic [7:0]  bus_latch_q, bus_latch_d;
  logic [15:0] decay_cnt_q, decay_cnt_d;
  logic [7:0]  potx_val, poty_val;
  logic [7:0]  rd_val;
  logic        access;

  // Every strobed edge is an access regardless of clk_en.
  assign access = !n_cs;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    if (clk_en) begin
      // pcnt wraps 255 -> 0 exactly when the phase flips.
      pcnt_d = pcnt_q + 8'd1;
      if (pcnt_q == POT_LAST) begin
        state_d = (state_q == POT_DISCHARGE) ? POT_CHARGE : POT_DISCHARGE;
      end
    end
  end

  assign pot_discharge = (state_q == POT_DISCHARGE);

  sid_pot_channel u_pot_x (
    .clk     (clk),
    .n_reset (n_reset),
    .clk_en  (clk_en),
    .state   (state_q),
    .pcnt    (pcnt_q),
    .cmp     (pot_x_cmp),
    .value   (potx_val)
  );

  sid_pot_channel u_pot_y (
    .clk     (clk),
    .n_reset (n_reset),
    .clk_en  (clk_en),
    .state   (state_q),
    .pcnt    (pcnt_q),
    .cmp     (pot_y_cmp),
    .value   (poty_val)
  );

  always_comb begin
    case (addr)
      SID_POTX: rd_val = potx_val;
      SID_POTY: rd_val = poty_val;
      SID_OSC3: rd_val = osc3;
      SID_ENV3: rd_val = env3;
      default:  rd_val = bus_latch_q;
    endcase
  end

  always_comb begin
    data_out_d  = data_out_q;
    bus_latch_d = bus_latch_q;
    decay_cnt_d = decay_cnt_q;
    // An access on a decay tick takes priority: reload and load, never clear.
    if (access) begin
      decay_cnt_d = DECAY_RELOAD;
      if (rw) begin
        data_out_d  = rd_val;
        bus_latch_d = rd_val;
      end else begin
        bus_latch_d = data_in;
      end
    end else if (clk_en && decay_cnt_q != 16'd0) begin
      decay_cnt_d = decay_cnt_q - 16'd1;
      if (decay_cnt_q == 16'd1) begin
        bus_latch_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= POT_DISCHARGE;
      pcnt_q      <= 8'h00;
      data_out_q  <= 8'h00;
      bus_latch_q <= 8'h00;
      decay_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      data_out_q  <= data_out_d;
      bus_latch_q <= bus_latch_d;
      decay_cnt_q <= decay_cnt_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_sid_readback.sv
// tb/tb_sid_readback.sv - scoreboard bench for sid_readback with a tick-count reference model

module tb_sid_readback;

  localparam int DECAY = 8;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       clk_en = 1'b0;
  logic [4:0] addr = 5'h00;
  logic [7:0] data_in = 8'h00;
  logic       n_cs = 1'b1;
  logic       rw = 1'b1;
  logic [7:0] osc3 = 8'h00;
  logic [7:0] env3 = 8'h00;
  logic       pot_x_cmp = 1'b0;
  logic       pot_y_cmp = 1'b0;
  logic       pot_discharge;
  logic [7:0] data_out;

  sid_readback #(.DECAY_TICKS(DECAY)) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .clk_en        (clk_en),
    .addr          (addr),
    .data_in       (data_in),
    .n_cs          (n_cs),
    .rw            (rw),
    .osc3          (osc3),
    .env3          (env3),
    .pot_x_cmp     (pot_x_cmp),
    .pot_y_cmp     (pot_y_cmp),
    .pot_discharge (pot_discharge),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] held = 8'h00;
  bit         mon_en = 1'b0;

  // Reference model: ticks since reset, ticks since last access, planned
  // first-hit counts per period (256 = comparator never rises in CHARGE).
  int         tick_n = 0;
  int         since = 0;
  int         cx = 256;
  int         cy = 256;
  int         pidx = 0;
  int         pend = 0;
  logic [7:0] potx_m = 8'h00;
  logic [7:0] poty_m = 8'h00;
  logic [7:0] last_val = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic logic [7:0] commit_val(input int c);
    return (c >= 255) ? 8'hFF : 8'(c);
  endfunction

  // During DISCHARGE the comparator is noise; during CHARGE it is high on
  // [c, c+2] and again on [c+20, c+25], so the first rise is at c.
  function automatic logic cmp_drive(input int p, input int c);
    int pc;
    if (p < 256) return 1'($urandom_range(0, 1));
    pc = p - 256;
    return (pc >= c && pc <= c + 2) || (pc >= c + 20 && pc <= c + 25);
  endfunction

  function automatic logic [7:0] rd_model(input logic [4:0] a, input logic [7:0] o, input logic [7:0] e);
    case (a)
      5'h19:   return potx_m;
      5'h1A:   return poty_m;
      5'h1B:   return o;
      5'h1C:   return e;
      default: return (since >= DECAY) ? 8'h00 : last_val;
    endcase
  endfunction

  task automatic next_plan();
    case (pidx)
      0: begin cx = 100; cy = 256; end
      1: begin cx = 0;   cy = 255; end
      default: begin cx = $urandom_range(0, 256); cy = $urandom_range(0, 256); end
    endcase
    pidx++;
  endtask

  task automatic step(input bit en, input bit acc, input bit rd, input logic [4:0] a,
                      input logic [7:0] d, input logic [7:0] o, input logic [7:0] e);
    int p;
    logic [7:0] v;
    @(negedge clk);
    p = tick_n % 512;
    chk("pot_discharge", pot_discharge, p < 256);
    clk_en = en; n_cs = !acc; rw = rd; addr = a; data_in = d; osc3 = o; env3 = e;
    pot_x_cmp = cmp_drive(p, cx);
    pot_y_cmp = cmp_drive(p, cy);
    if (acc) begin
      v = rd ? rd_model(a, o, e) : d;
      if (rd) exp_q.push_back(v);
      last_val = v;
      since = 0;
    end else if (en && since < 65536) begin
      since++;
    end
    if (en) begin
      if (p == 511) begin
        potx_m = commit_val(cx);
        poty_m = commit_val(cy);
        next_plan();
        pend = 2;
      end
      tick_n++;
    end
    @(posedge clk);
  endtask

  task automatic rand_step(input bit force_en);
    bit en, acc, rd;
    logic [4:0] a;
    int p;
    p = tick_n % 512;
    en = force_en || ($urandom_range(0, 3) != 0);
    acc = ($urandom_range(0, 9) == 0);
    rd = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: a = 5'h19;
      1: a = 5'h1A;
      2: a = 5'h1B;
      3: a = 5'h1C;
      default: a = 5'($urandom);
    endcase
    if (pend > 0) begin
      acc = 1'b1; rd = 1'b1; a = (pend == 2) ? 5'h19 : 5'h1A; pend--;
    end else if (p == 511 && en) begin
      acc = 1'b1; rd = 1'b1; a = 5'h19;
    end
    step(en, acc, rd, a, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    n_reset = 1'b0; n_cs = 1'b1; clk_en = 1'b0;
    tick_n = 0; since = 0; potx_m = 8'h00; poty_m = 8'h00; last_val = 8'h00;
    pend = 0; held = 8'h00;
    #1;
    mon_en = 1'b1;
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_pot_discharge", pot_discharge, 1'b1);
    @(negedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      bit was_rd;
      logic [7:0] e;
      @(posedge clk);
      was_rd = mon_en && n_reset && !n_cs && rw;
      @(negedge clk);
      if (mon_en) begin
        if (was_rd) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_empty: read strobe seen with no expected value, data_out %0h", data_out);
          end else begin
            e = exp_q.pop_front();
            chk("read_data", data_out, e);
            held = e;
          end
        end else begin
          chk("data_hold", data_out, held);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : stimulus
    int guard;
    do_reset();
    next_plan();

    step(0, 1, 1, 5'h19, 8'h00, 8'h11, 8'h22);
    repeat (256) step(1, 0, 0, 5'h00, 8'h00, 8'($urandom), 8'($urandom));

    guard = 0;
    while (pidx < 4 && guard < 20000) begin
      rand_step(0);
      guard++;
    end
    chk("period_progress", pidx >= 4, 1'b1);

    step(0, 1, 1, 5'h1B, 8'h00, 8'hA5, 8'h3C);
    step(0, 1, 1, 5'h1C, 8'h00, 8'hA5, 8'h3C);
    repeat (4) step(0, 0, 0, 5'h00, 8'h00, 8'($urandom), 8'($urandom));

    step(0, 1, 0, 5'h00, 8'h5A, 8'h00, 8'h00);
    step(1, 1, 1, 5'h05, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < DECAY; i++) begin
      step(1, 0, 0, 5'h00, 8'h00, 8'h00, 8'h00);
      step(0, 0, 0, 5'h00, 8'h00, 8'h00, 8'h00);
    end
    step(0, 1, 1, 5'h05, 8'h00, 8'h00, 8'h00);
    step(0, 1, 0, 5'h00, 8'h5A, 8'h00, 8'h00);
    step(0, 1, 1, 5'h05, 8'h00, 8'h00, 8'h00);
    repeat (DECAY - 1) step(1, 0, 0, 5'h00, 8'h00, 8'h00, 8'h00);
    step(1, 1, 1, 5'h05, 8'h00, 8'h00, 8'h00);
    repeat (DECAY - 1) step(1, 0, 0, 5'h00, 8'h00, 8'h00, 8'h00);
    step(0, 1, 1, 5'h05, 8'h00, 8'h00, 8'h00);
    step(1, 0, 0, 5'h00, 8'h00, 8'h00, 8'h00);
    step(0, 1, 1, 5'h05, 8'h00, 8'h00, 8'h00);

    guard = 0;
    while (tick_n % 512 != 0 && guard < 2000) begin
      rand_step(1);
      guard++;
    end
    cx = 40; cy = 256;
    guard = 0;
    while (tick_n % 512 != 256 + 60 && guard < 2000) begin
      step(1, 0, 0, 5'h00, 8'h00, 8'($urandom), 8'($urandom));
      guard++;
    end
    do_reset();
    cx = 200; cy = 10;
    step(0, 1, 1, 5'h19, 8'h00, 8'h00, 8'h00);
    repeat (512) rand_step(1);
    repeat (6) rand_step(0);

    repeat (3) step(0, 0, 0, 5'h00, 8'h00, 8'h00, 8'h00);
    chk("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
